niosii_system_sysid_checker: RTL and testbench

//  Avalon-MM read master that queries the system-ID slave (word 0 = ID, word 1 = timestamp).

---
 rtl/niosii_system_sysid_checker_pkg.sv | 19 +
 rtl/niosii_system_sysid_checker_if.sv | 18 +
 rtl/niosii_system_sysid_checker_timeout.sv | 24 ++
 rtl/niosii_system_sysid_checker.sv | 125 ++++++++++++
 tb/tb_niosii_system_sysid_checker.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared constants for the sysid checker: FSM encoding, slave word offsets and
// the build-time identity the checker expects to find.
package niosii_system_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT
  } state_e;

  localparam logic [31:0] ID_OFS = 32'd0;
  localparam logic [31:0] TS_OFS = 32'd4;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1486161713;

endpackage

// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
interface niosii_system_sysid_checker_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/niosii_system_sysid_checker_timeout.sv
// Per-transaction cycle budget: clearable saturating counter; o_expired marks
// the last cycle of the budget, so leaving on that edge lands exactly on LIMIT.
module niosii_system_sysid_checker_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);
  localparam logic [TW-1:0] TOP  = TW'(LIMIT);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) r_count <= '0;
    else if (i_enable && r_count != TOP) r_count <= r_count + 1'b1;
  end

  assign o_expired = (r_count >= LAST);
endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Boot-path health check: reads sysid ID and timestamp over Avalon-MM and
// reports match, mismatch or timeout with a one-cycle done pulse.
module niosii_system_sysid_checker
  import niosii_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  niosii_system_sysid_checker_if.master avm,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_match,
  output logic                          o_timeout_err,
  output logic [31:0]                   o_id_value,
  output logic [31:0]                   o_ts_value
);
  state_e      r_state, w_next;
  logic        w_go, w_clear, w_cap_id, w_cap_ts, w_fin, w_tmo;
  logic        w_read, w_expired, w_enable;
  logic [31:0] w_addr;
  logic        r_done, r_match, r_tmo;
  logic [31:0] r_id, r_ts;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_go     = 1'b0;
    w_clear  = 1'b0;
    w_cap_id = 1'b0;
    w_cap_ts = 1'b0;
    w_fin    = 1'b0;
    w_tmo    = 1'b0;
    w_read   = 1'b0;
    w_addr   = BASE_ADDR + ID_OFS;
    case (r_state)
      // The done cycle still belongs to the finishing sequence, so a start there is dropped.
      ST_IDLE: if (i_start && !r_done) begin
        w_go    = 1'b1;
        w_clear = 1'b1;
        w_next  = ST_ID_REQ;
      end
      ST_ID_REQ: begin
        w_read = 1'b1;
        if (w_expired)                 w_tmo  = 1'b1;
        else if (!avm.avm_waitrequest) w_next = ST_ID_WAIT;
      end
      ST_ID_WAIT: begin
        if (avm.avm_readdatavalid) begin
          w_cap_id = 1'b1;
          w_clear  = 1'b1;
          w_next   = ST_TS_REQ;
        end else if (w_expired) w_tmo = 1'b1;
      end
      ST_TS_REQ: begin
        w_read = 1'b1;
        w_addr = BASE_ADDR + TS_OFS;
        if (w_expired)                 w_tmo  = 1'b1;
        else if (!avm.avm_waitrequest) w_next = ST_TS_WAIT;
      end
      ST_TS_WAIT: begin
        w_addr = BASE_ADDR + TS_OFS;
        if (avm.avm_readdatavalid) begin
          w_cap_ts = 1'b1;
          w_fin    = 1'b1;
          w_next   = ST_IDLE;
        end else if (w_expired) w_tmo = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_tmo) w_next = ST_IDLE;
  end

  assign w_enable = (r_state != ST_IDLE);

  niosii_system_sysid_checker_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_tmo   <= 1'b0;
      r_id    <= '0;
      r_ts    <= '0;
    end else begin
      r_done <= w_fin | w_tmo;
      if (w_go) begin
        r_match <= 1'b0;
        r_tmo   <= 1'b0;
      end
      if (w_tmo) begin
        r_match <= 1'b0;
        r_tmo   <= 1'b1;
      end
      if (w_cap_id) r_id <= avm.avm_readdata;
      if (w_cap_ts) begin
        r_ts    <= avm.avm_readdata;
        r_match <= (r_id == EXPECTED_ID) && (avm.avm_readdata == EXPECTED_TS);
      end
    end
  end

  assign avm.avm_read    = w_read;
  assign avm.avm_address = w_addr;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;
  assign o_match         = r_match;
  assign o_timeout_err   = r_tmo;
  assign o_id_value      = r_id;
  assign o_ts_value      = r_ts;
endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the sysid checker: a table of slave behaviours with
// hand-computed done cycles and results, plus reset-based corner sequences.
module tb_niosii_system_sysid_checker;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] TSX  = 32'd1486161713;
  localparam int          TMO  = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, match, tmo;
  logic [31:0] idv, tsv;

  niosii_system_sysid_checker_if bus ();

  niosii_system_sysid_checker #(
    .BASE_ADDR(BASE), .EXPECTED_ID(32'd0), .EXPECTED_TS(TSX), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .i_clock(clk), .i_reset(rst), .avm(bus.master), .i_start(start),
    .o_busy(busy), .o_done(done), .o_match(match), .o_timeout_err(tmo),
    .o_id_value(idv), .o_ts_value(tsv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mask;     // cycles (after start) in which start is re-asserted
    int          wr_id, wr_ts;
    bit          rsp_id, rsp_ts;
    logic [31:0] d_id, d_ts;
    int          exp_done;
    bit          exp_match, exp_tmo;
    logic [31:0] exp_id, exp_ts;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Acts as the slave for one sequence; cycle 0 is the start cycle.
  task automatic run_seq(input vec_t v, output int first_done, output int n_done, output int bad);
    int ph, wcnt;
    bit rdv_next;
    first_done = -1; n_done = 0; bad = 0; ph = 0; wcnt = 0; rdv_next = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start = v.mask[cyc];
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == 1 && (match || tmo)) bad++;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      bus.avm_waitrequest   = 1'b0;
      if (rdv_next) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = (ph == 1) ? v.d_id : v.d_ts;
        ph++;
        rdv_next = 1'b0;
      end else if (first_done >= 0 && cyc == first_done + 1) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'hDEAD_BEEF;
      end
      if (bus.avm_read) begin
        if (first_done >= 0 || (ph != 0 && ph != 2)) bad++;
        else begin
          if (bus.avm_address !== (BASE + ((ph == 2) ? 32'd4 : 32'd0))) bad++;
          if (wcnt < ((ph == 0) ? v.wr_id : v.wr_ts)) begin
            bus.avm_waitrequest = 1'b1;
            wcnt++;
          end else begin
            wcnt = 0;
            ph++;
            rdv_next = (ph == 1) ? v.rsp_id : v.rsp_ts;
          end
        end
      end
      if (first_done < 0 && !busy && !done) bad++;
      if (first_done >= 0 && busy) bad++;
      if (first_done >= 0 && cyc >= first_done + 4) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_waitrequest   = 1'b0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    int fd, nd, bad;
    run_seq(v, fd, nd, bad);
    chk($sformatf("v%0d done_cycle", i), fd, v.exp_done);
    chk($sformatf("v%0d done_pulses", i), nd, 1);
    chk($sformatf("v%0d protocol", i), bad, 0);
    chk($sformatf("v%0d match", i), match, v.exp_match);
    chk($sformatf("v%0d timeout_err", i), tmo, v.exp_tmo);
    chk($sformatf("v%0d id_value", i), idv, v.exp_id);
    chk($sformatf("v%0d ts_value", i), tsv, v.exp_ts);
    chk($sformatf("v%0d idle_read", i), bus.avm_read, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    //          mask   wid wts rid rts d_id          d_ts         done m t  exp_id        exp_ts
    vecs[0]  = '{64'h0,  0,  0, 1, 1, 32'd0,        TSX,          5, 1, 0, 32'd0,        TSX};
    vecs[1]  = '{64'h0,  0,  0, 1, 1, 32'd0,        32'd1,        5, 0, 0, 32'd0,        32'd1};
    vecs[2]  = '{64'h0,  3,  3, 1, 1, 32'd0,        TSX,         11, 1, 0, 32'd0,        TSX};
    vecs[3]  = '{64'h0,  1,  2, 1, 1, 32'd0,        TSX,          8, 1, 0, 32'd0,        TSX};
    vecs[4]  = '{64'h0,  0,  0, 1, 1, 32'h1234,     32'hABCD,     5, 0, 0, 32'h1234,     32'hABCD};
    vecs[5]  = '{64'h0,  0,  0, 0, 0, 32'h9999,     32'h9999,     9, 0, 1, 32'h1234,     32'hABCD};
    vecs[6]  = '{64'h0,100,  0, 0, 0, 32'h9999,     32'h9999,     9, 0, 1, 32'h1234,     32'hABCD};
    vecs[7]  = '{64'h0,  0,  0, 1, 0, 32'h55,       32'h9999,    11, 0, 1, 32'h55,       32'hABCD};
    vecs[8]  = '{64'h0,  0,  6, 1, 1, 32'd0,        TSX,         11, 1, 0, 32'd0,        TSX};
    vecs[9]  = '{64'h0,  0,  7, 1, 1, 32'h77,       32'h9999,    11, 0, 1, 32'h77,       TSX};
    vecs[10] = '{64'h24, 0,  0, 1, 1, 32'd0,        TSX,          5, 1, 0, 32'd0,        TSX};
    vecs[11] = '{64'h0,  0,  0, 1, 1, 32'd0,        TSX,          5, 1, 0, 32'd0,        TSX};

    rst = 1'b1; start = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0; bus.avm_readdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset match", match, 1'b0);
    chk("reset timeout_err", tmo, 1'b0);
    chk("reset id_value", idv, 32'd0);
    chk("reset ts_value", tsv, 32'd0);
    chk("reset read", bus.avm_read, 1'b0);
    chk("reset address", bus.avm_address, BASE);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) check_vec(i, vecs[i]);

    // Reset while waiting for the timestamp, then a stray response.
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'h4242;
    @(posedge clk); #1;
    bus.avm_readdatavalid = 1'b0; bus.avm_readdata = '0;
    chk("rst_seq ts_req read", bus.avm_read, 1'b1);
    chk("rst_seq ts_req address", bus.avm_address, BASE + 32'd4);
    @(posedge clk); #1;
    chk("rst_seq ts_wait busy", busy, 1'b1);
    chk("rst_seq id captured", idv, 32'h4242);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_seq busy", busy, 1'b0);
    chk("rst_seq done", done, 1'b0);
    chk("rst_seq match", match, 1'b0);
    chk("rst_seq timeout_err", tmo, 1'b0);
    chk("rst_seq id_value", idv, 32'd0);
    chk("rst_seq ts_value", tsv, 32'd0);
    chk("rst_seq read", bus.avm_read, 1'b0);
    chk("rst_seq address", bus.avm_address, BASE);
    rst = 1'b0;
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = TSX;
    @(posedge clk); #1;
    bus.avm_readdatavalid = 1'b0; bus.avm_readdata = '0;
    chk("late_rdv id_value", idv, 32'd0);
    chk("late_rdv ts_value", tsv, 32'd0);
    chk("late_rdv done", done, 1'b0);
    chk("late_rdv busy", busy, 1'b0);
    check_vec(100, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
